// File: rtl/mips_mc_cu.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over one shared memory and ALU, with memory timeout, illegal trap and retire counter.
module mips_mc_cu #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       function_bits,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_operation,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010, F_JR  = 6'b001000;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001, ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              bus_error_q, bus_error_d;
  logic              timeout;

  assign timeout     = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
  assign illegal     = illegal_q;
  assign bus_error   = bus_error_q;
  assign instr_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Everything is forced low while rst is high so the reset cycle issues no strobe.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    cnt_d         = cnt_q;
    illegal_d     = illegal_q;
    bus_error_d   = bus_error_q;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_operation = 3'b000;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read      = 1'b1;
          alu_src_b     = 2'd1;
          alu_operation = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout) begin
            state_d     = S_ERROR;
            bus_error_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b     = 2'd3;
          alu_operation = ALU_ADD;
          case (opcode)
            OP_RTYPE: begin
              case (function_bits)
                F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_d = S_EXEC_R;
                F_JR:    state_d = S_JR;
                default: begin state_d = S_ERROR; illegal_d = 1'b1; end
              endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J, OP_JAL:   state_d = S_JUMP;
            default: begin state_d = S_ERROR; illegal_d = 1'b1; end
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          case (function_bits)
            F_SUB:   alu_operation = ALU_SUB;
            F_AND:   alu_operation = ALU_AND;
            F_OR:    alu_operation = ALU_OR;
            F_SLT:   alu_operation = ALU_SLT;
            default: alu_operation = ALU_ADD;
          endcase
          state_d = S_WB_R;
        end
        S_WB_R: begin
          reg_dst   = 2'd1;
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          case (opcode)
            OP_SLTI: alu_operation = ALU_SLT;
            OP_ANDI: alu_operation = ALU_AND;
            OP_ORI:  alu_operation = ALU_OR;
            default: alu_operation = ALU_ADD;
          endcase
          state_d = S_WB_I;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'd2;
          alu_operation = ALU_ADD;
          state_d       = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        // The data access holds its request until mem_ready, same timeout as fetch.
        S_MEM_RD, S_MEM_WR: begin
          iord      = 1'b1;
          mem_read  = (state_q == S_MEM_RD);
          mem_write = (state_q == S_MEM_WR);
          if (mem_ready) begin
            state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
          end else if (timeout) begin
            state_d     = S_ERROR;
            bus_error_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_MEM_WB: begin
          mem_to_reg = 2'd1;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_operation = ALU_SUB;
          pc_src        = 2'd1;
          pc_write      = ((opcode == OP_BEQ) && zero_flag) || ((opcode == OP_BNE) && !zero_flag);
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
          if (opcode == OP_JAL) begin
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            reg_write  = 1'b1;
          end
          state_d = S_FETCH;
        end
        S_JR: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_ERROR;
      endcase
      if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_ERROR)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_mc_cu.sv
// Directed testbench for mips_mc_cu: per-cycle control vectors are compared against
// hand-derived expectations, plus flag and retire-counter checks.
module tb_mips_mc_cu;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] function_bits;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_operation;
  logic       illegal, bus_error;
  logic [3:0] instr_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt = 4'd0;

  mips_mc_cu #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .function_bits(function_bits),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
    .illegal(illegal), .bus_error(bus_error), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word: {pc_write,pc_src,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_operation}
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation};

  localparam logic [17:0] E_ZERO    = 18'd0;
  localparam logic [17:0] E_FETCH   = {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 3'b010};
  localparam logic [17:0] E_STALL   = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 3'b010};
  localparam logic [17:0] E_DECODE  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 3'b010};
  localparam logic [17:0] E_EXR_ADD = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b010};
  localparam logic [17:0] E_EXR_SUB = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b110};
  localparam logic [17:0] E_WB_R    = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_EXI_ORI = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 3'b001};
  localparam logic [17:0] E_WB_I    = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_MADDR   = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 3'b010};
  localparam logic [17:0] E_MRD     = {1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_MWB     = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_MWR     = {1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_BEQ_T   = {1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b110};
  localparam logic [17:0] E_BNE_NT  = {1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b110};
  localparam logic [17:0] E_JAL     = {1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 3'b000};
  localparam logic [17:0] E_JR      = {1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000};

  // One clock: drive inputs on the falling edge, then let combinational outputs settle.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                      input logic mr, input logic r);
    @(negedge clk);
    opcode = op; function_bits = fn; zero_flag = zf; mem_ready = mr; rst = r;
    #1;
  endtask

  task automatic test_reset();
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctl !== E_ZERO) begin errors++; $display("[TB] FAIL reset_ctl: got %h expected %h", ctl, E_ZERO); end
    checks++;
    if ({illegal, bus_error, instr_count} !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_flags: got ill=%b bus=%b cnt=%0d expected 0/0/0", illegal, bus_error, instr_count);
    end
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL) begin errors++; $display("[TB] FAIL reset_fetch: got %h expected %h", ctl, E_STALL); end
    exp_cnt = 4'd0;
  endtask

  task automatic test_r_type();
    logic [17:0] exp_v [2][4];
    logic [5:0]  fn [2];
    exp_v = '{'{E_FETCH, E_DECODE, E_EXR_ADD, E_WB_R}, '{E_FETCH, E_DECODE, E_EXR_SUB, E_WB_R}};
    fn = '{6'b100000, 6'b100010};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        step(6'b000000, fn[k], 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== exp_v[k][i]) begin
          errors++; $display("[TB] FAIL r_type%0d_cyc%0d: got %h expected %h", k, i + 1, ctl, exp_v[k][i]);
        end
      end
      exp_cnt++;
      step(6'b000000, fn[k], 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== E_STALL || instr_count !== exp_cnt) begin
        errors++; $display("[TB] FAIL r_type%0d_retire: got ctl=%h cnt=%0d expected %h cnt=%0d", k, ctl, instr_count, E_STALL, exp_cnt);
      end
    end
  endtask

  task automatic test_i_type();
    logic [17:0] exp_v [4];
    exp_v = '{E_FETCH, E_DECODE, E_EXI_ORI, E_WB_I};
    for (int i = 0; i < 4; i++) begin
      step(6'b001101, 6'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("[TB] FAIL ori_cyc%0d: got %h expected %h", i + 1, ctl, exp_v[i]); end
    end
    exp_cnt++;
    step(6'b001101, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || instr_count !== exp_cnt) begin
      errors++; $display("[TB] FAIL ori_retire: got ctl=%h cnt=%0d expected %h cnt=%0d", ctl, instr_count, E_STALL, exp_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [17:0] exp_v [8];
    logic        mr [8];
    exp_v = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB};
    mr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(6'b100011, 6'd0, 1'b0, mr[i], 1'b0);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("[TB] FAIL lw_cyc%0d: got %h expected %h", i + 1, ctl, exp_v[i]); end
    end
    exp_cnt++;
    step(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || instr_count !== exp_cnt || bus_error !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_retire: got ctl=%h cnt=%0d bus=%b expected %h cnt=%0d bus=0", ctl, instr_count, bus_error, E_STALL, exp_cnt);
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp_v [4];
    exp_v = '{E_FETCH, E_DECODE, E_MADDR, E_MWR};
    for (int i = 0; i < 4; i++) begin
      step(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("[TB] FAIL sw_cyc%0d: got %h expected %h", i + 1, ctl, exp_v[i]); end
    end
    exp_cnt++;
    step(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || instr_count !== exp_cnt) begin
      errors++; $display("[TB] FAIL sw_retire: got ctl=%h cnt=%0d expected %h cnt=%0d", ctl, instr_count, E_STALL, exp_cnt);
    end
  endtask

  task automatic test_branch();
    logic [17:0] exp_v [2][3];
    logic [5:0]  op [2];
    exp_v = '{'{E_FETCH, E_DECODE, E_BEQ_T}, '{E_FETCH, E_DECODE, E_BNE_NT}};
    op = '{6'b000100, 6'b000101};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(op[k], 6'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== exp_v[k][i]) begin
          errors++; $display("[TB] FAIL branch%0d_cyc%0d: got %h expected %h", k, i + 1, ctl, exp_v[k][i]);
        end
      end
      exp_cnt++;
      step(op[k], 6'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ctl !== E_STALL || instr_count !== exp_cnt) begin
        errors++; $display("[TB] FAIL branch%0d_retire: got ctl=%h cnt=%0d expected %h cnt=%0d", k, ctl, instr_count, E_STALL, exp_cnt);
      end
    end
  endtask

  task automatic test_jump();
    logic [17:0] exp_v [2][3];
    logic [5:0]  op [2];
    logic [5:0]  fn [2];
    exp_v = '{'{E_FETCH, E_DECODE, E_JAL}, '{E_FETCH, E_DECODE, E_JR}};
    op = '{6'b000011, 6'b000000};
    fn = '{6'b000000, 6'b001000};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(op[k], fn[k], 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== exp_v[k][i]) begin
          errors++; $display("[TB] FAIL jump%0d_cyc%0d: got %h expected %h", k, i + 1, ctl, exp_v[k][i]);
        end
      end
      exp_cnt++;
      step(op[k], fn[k], 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== E_STALL || instr_count !== exp_cnt) begin
        errors++; $display("[TB] FAIL jump%0d_retire: got ctl=%h cnt=%0d expected %h cnt=%0d", k, ctl, instr_count, E_STALL, exp_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    step(6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctl !== E_FETCH) begin errors++; $display("[TB] FAIL illegal_fetch: got %h expected %h", ctl, E_FETCH); end
    step(6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctl !== E_DECODE || illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_decode: got ctl=%h ill=%b expected %h ill=0", ctl, illegal, E_DECODE);
    end
    for (int i = 0; i < 20; i++) begin
      step(6'b111111, 6'd0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (ctl !== E_ZERO || illegal !== 1'b1 || bus_error !== 1'b0 || instr_count !== exp_cnt) begin
        errors++; $display("[TB] FAIL illegal_hold%0d: got ctl=%h ill=%b bus=%b cnt=%0d expected %h ill=1 bus=0 cnt=%0d",
                           i, ctl, illegal, bus_error, instr_count, E_ZERO, exp_cnt);
      end
    end
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctl !== E_ZERO) begin errors++; $display("[TB] FAIL illegal_rst_ctl: got %h expected %h", ctl, E_ZERO); end
    exp_cnt = 4'd0;
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || illegal !== 1'b0 || instr_count !== exp_cnt) begin
      errors++; $display("[TB] FAIL illegal_recover: got ctl=%h ill=%b cnt=%0d expected %h ill=0 cnt=0", ctl, illegal, instr_count, E_STALL);
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] exp_v [3];
    exp_v = '{E_FETCH, E_DECODE, E_EXR_ADD};
    for (int i = 0; i < 3; i++) begin
      step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("[TB] FAIL midrst_cyc%0d: got %h expected %h", i + 1, ctl, exp_v[i]); end
    end
    step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctl !== E_ZERO) begin errors++; $display("[TB] FAIL midrst_nowrite: got %h expected %h", ctl, E_ZERO); end
    step(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || instr_count !== 4'd0) begin
      errors++; $display("[TB] FAIL midrst_fetch: got ctl=%h cnt=%0d expected %h cnt=0", ctl, instr_count, E_STALL);
    end
    exp_cnt = 4'd0;
  endtask

  task automatic test_wrap();
    logic [17:0] exp_v [3];
    exp_v = '{E_FETCH, E_DECODE, E_JR};
    for (int n = 1; n <= 16; n++) begin
      for (int i = 0; i < 3; i++) begin
        step(6'b000000, 6'b001000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== exp_v[i]) begin errors++; $display("[TB] FAIL wrap_jr%0d_cyc%0d: got %h expected %h", n, i + 1, ctl, exp_v[i]); end
      end
      exp_cnt++;
      if (n >= 15) begin
        step(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (instr_count !== exp_cnt) begin
          errors++; $display("[TB] FAIL wrap_count%0d: got %0d expected %0d", n, instr_count, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_timeout();
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== E_STALL || bus_error !== 1'b0) begin
        errors++; $display("[TB] FAIL timeout_wait%0d: got ctl=%h bus=%b expected %h bus=0", i, ctl, bus_error, E_STALL);
      end
    end
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctl !== E_ZERO || bus_error !== 1'b1 || illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_err: got ctl=%h bus=%b ill=%b expected %h bus=1 ill=0", ctl, bus_error, illegal, E_ZERO);
    end
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== E_STALL || bus_error !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_recover: got ctl=%h bus=%b expected %h bus=0", ctl, bus_error, E_STALL);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; function_bits = 6'd0; zero_flag = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_i_type();
    test_lw_stall();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_mid_reset();
    test_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
